// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between instruction fetch and the memory stage.
// Latency: grant is combinational in the request cycle; read data returns exactly one cycle later.
// Backpressure: a requester that is not granted sees its stall output high and re-requests next cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_stall/if_valid/if_rdata          fetch side
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_stall/dm_valid/dm_rdata   data side
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata         RAM side
// Optional feature: define ARB_FAIRNESS_EN to force a fetch grant after MAX_DATA_WINS
// consecutive contested data grants. Without it, data has strict priority.
module mem_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_DATA_WINS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_stall,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_stall,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // The counter is 4 bits wide, so the threshold must fit in 1..15.
    if (MAX_DATA_WINS < 1 || MAX_DATA_WINS > 15) begin : g_bad_max
        $error("mem_arbiter: MAX_DATA_WINS must be in 1..15");
    end

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_FETCH = 2'd1,
        PEND_DATA  = 2'd2
    } pend_t;

    pend_t pend;
    pend_t pend_nxt;
    logic  gnt_if;
    logic  gnt_dm;

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] MAX_WINS = 4'(MAX_DATA_WINS);
    logic [3:0] win_cnt;
`endif

    // Grant selection. While reset is asserted nothing is granted, so both
    // stalls simply mirror their requests and the RAM stays idle.
    always_comb begin
        gnt_if = 1'b0;
        gnt_dm = 1'b0;
        if (rst) begin
            if (dm_req && if_req) begin
`ifdef ARB_FAIRNESS_EN
                if (win_cnt == MAX_WINS) gnt_if = 1'b1;
                else                     gnt_dm = 1'b1;
`else
                gnt_dm = 1'b1;
`endif
            end else if (dm_req) begin
                gnt_dm = 1'b1;
            end else if (if_req) begin
                gnt_if = 1'b1;
            end
        end
    end

    // Memory port drive; all fields are zero when idle so the bus is quiet.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_dm) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (gnt_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    assign if_stall = if_req & ~gnt_if;
    assign dm_stall = dm_req & ~gnt_dm;

    // Track who owns the read data returning next cycle. Stores need no response.
    always_comb begin
        pend_nxt = PEND_NONE;
        if (gnt_if)               pend_nxt = PEND_FETCH;
        else if (gnt_dm && !dm_we) pend_nxt = PEND_DATA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend <= PEND_NONE;
        else      pend <= pend_nxt;
    end

    assign if_valid = (pend == PEND_FETCH);
    assign dm_valid = (pend == PEND_DATA);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = dm_valid ? mem_rdata : '0;

`ifdef ARB_FAIRNESS_EN
    // Counts data wins while fetch is waiting. A fetch grant, or fetch going
    // away while data is active, restarts the count; fully idle cycles hold it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt <= 4'd0;
        end else if (gnt_if) begin
            win_cnt <= 4'd0;
        end else if (gnt_dm && if_req) begin
            win_cnt <= win_cnt + 4'd1;
        end else if (!if_req && dm_req) begin
            win_cnt <= 4'd0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a behavioural sync RAM.
// Latency: checks one-cycle read return and same-cycle grant/stall behaviour.
// Backpressure: exercises contention, optional fairness and mid-cycle reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_stall;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_stall;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;

    mem_arbiter #(.AW(32), .DW(32), .MAX_DATA_WINS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_stall  (if_stall),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_stall  (dm_stall),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: unwritten word i reads as 0xA0000000 | i.
    logic [31:0] ram [int];
    initial mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[int'(mem_addr[11:2])] = mem_wdata;
            else if (ram.exists(int'(mem_addr[11:2]))) mem_rdata <= ram[int'(mem_addr[11:2])];
            else mem_rdata <= 32'hA000_0000 | {22'd0, mem_addr[11:2]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_fetch;

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        #1;
        chk("rst_mem_en",   {31'd0, mem_en},   32'd0);
        chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("rst_if_stall", {31'd0, if_stall}, 32'd1);
        chk("rst_dm_stall", {31'd0, dm_stall}, 32'd1);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        if_req = 1'b0; dm_req = 1'b0;
        #1 rst = 1'b1;

        // Fetch stream 0x0, 0x4, 0x8.
        cyc(); if_req = 1'b1; if_addr = 32'h0; #1;
        chk("f0_mem_en",   {31'd0, mem_en},   32'd1);
        chk("f0_if_stall", {31'd0, if_stall}, 32'd0);
        chk("f0_mem_addr", mem_addr, 32'h0);
        chk("f0_if_valid", {31'd0, if_valid}, 32'd0);
        cyc(); if_addr = 32'h4; #1;
        chk("f1_mem_addr", mem_addr, 32'h4);
        chk("f1_if_valid", {31'd0, if_valid}, 32'd1);
        chk("f1_if_rdata", if_rdata, 32'hA000_0000);
        chk("f1_dm_valid", {31'd0, dm_valid}, 32'd0);
        cyc(); if_addr = 32'h8; #1;
        chk("f2_if_rdata", if_rdata, 32'hA000_0001);
        cyc(); if_req = 1'b0; #1;
        chk("f3_if_rdata", if_rdata, 32'hA000_0002);
        chk("f3_mem_en",   {31'd0, mem_en},   32'd0);
        chk("f3_dm_valid", {31'd0, dm_valid}, 32'd0);
        cyc(); #1;
        chk("f4_if_valid", {31'd0, if_valid}, 32'd0);

        // Store then load back.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; #1;
        chk("st_mem_we",    {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr",  mem_addr,  32'h100);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); dm_we = 1'b0; dm_wdata = 32'h0; #1;
        chk("st_no_valid",  {31'd0, dm_valid}, 32'd0);
        chk("ld_mem_we",    {31'd0, mem_we},   32'd0);
        chk("ld_mem_en",    {31'd0, mem_en},   32'd1);
        cyc(); dm_req = 1'b0; #1;
        chk("ld_dm_valid",  {31'd0, dm_valid}, 32'd1);
        chk("ld_dm_rdata",  dm_rdata, 32'hDEAD_BEEF);

        // Contention: load 0x100 and fetch 0x10.
        cyc(); dm_req = 1'b1; if_req = 1'b1; if_addr = 32'h10; #1;
        chk("c0_if_stall", {31'd0, if_stall}, 32'd1);
        chk("c0_dm_stall", {31'd0, dm_stall}, 32'd0);
        chk("c0_mem_addr", mem_addr, 32'h100);
        cyc(); dm_req = 1'b0; #1;
        chk("c1_if_stall", {31'd0, if_stall}, 32'd0);
        chk("c1_mem_addr", mem_addr, 32'h10);
        chk("c1_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        cyc(); if_req = 1'b0; #1;
        chk("c2_if_valid", {31'd0, if_valid}, 32'd1);
        chk("c2_if_rdata", if_rdata, 32'hA000_0004);

        // Response and new grant in the same cycle.
        cyc(); if_req = 1'b1; if_addr = 32'hC; #1;
        chk("b0_mem_en", {31'd0, mem_en}, 32'd1);
        cyc(); if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h100; #1;
        chk("b1_if_rdata", if_rdata, 32'hA000_0003);
        chk("b1_mem_addr", mem_addr, 32'h100);
        cyc(); dm_req = 1'b0; #1;
        chk("b2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        chk("b2_if_valid", {31'd0, if_valid}, 32'd0);

        // Both held for 10 cycles; bit i set means fetch should win cycle i.
`ifdef ARB_FAIRNESS_EN
        exp_fetch = 10'b10_0001_0000;
`else
        exp_fetch = 10'b00_0000_0000;
`endif
        cyc(); if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_addr = 32'h100;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("fair%0d_if_stall", i), {31'd0, if_stall}, {31'd0, ~exp_fetch[i]});
            chk($sformatf("fair%0d_dm_stall", i), {31'd0, dm_stall}, {31'd0, exp_fetch[i]});
            cyc();
        end
        if_req = 1'b0; dm_req = 1'b0;

        // Reset while a load response is being returned.
        cyc(); dm_req = 1'b1; dm_addr = 32'h100; #1;
        chk("r0_mem_en", {31'd0, mem_en}, 32'd1);
        cyc();
        chk("r1_dm_valid", {31'd0, dm_valid}, 32'd1);
        #1 rst = 1'b0; #1;
        chk("r2_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("r2_dm_rdata", dm_rdata, 32'd0);
        chk("r2_mem_en",   {31'd0, mem_en},   32'd0);
        chk("r2_dm_stall", {31'd0, dm_stall}, 32'd1);
        dm_req = 1'b0;
        cyc(); cyc(); rst = 1'b1; #1;
        chk("r3_dm_valid", {31'd0, dm_valid}, 32'd0);
        cyc(); #1;
        chk("r4_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("r4_mem_en",   {31'd0, mem_en},   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
